cpu_program_sequencer: RTL and testbench
========================================

Name: cpu_program_sequencer

Overview:
- Sequences the 8-bit accumulator CPU: holds a small program memory, accepts program loads from a host over a valid/ready stream, and feeds one instruction per cycle to the CPU's instruction input.
- Clears the CPU before each run and supports halt, single-step and resume.
- Drives NOP whenever no instruction is being issued, so the CPU's accumulator holds its value between instructions.

Parameters:
AW, 4, program memory address width; DEPTH = 2**AW = 16 instructions
NOP, 8'hF0, instruction driven when idle (opcode 4'hF holds the accumulator)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
ld_valid  input  1  host load beat valid
ld_ready  output  1  sequencer can accept a load beat
ld_data  input  8  instruction word being loaded
ld_last  input  1  marks the final beat of a program load
start  input  1  pulse: begin run (IDLE/DONE) or resume (PAUSE)
halt_req  input  1  request to pause issue during RUN
step  input  1  pulse: issue exactly one instruction while in PAUSE
cpu_instr  output  8  registered instruction to CPU instruction input
cpu_rst  output  1  registered one-cycle reset pulse to the CPU
pc  output  AW  address of next instruction to issue
prog_len  output  AW+1  number of instructions currently loaded (0..DEPTH)
busy  output  1  high in CLEAR, RUN, PAUSE
done  output  1  high in DONE

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high. Reset and state are applied on the rising edge of clk.
- Reset values: state=IDLE, cpu_instr=NOP, cpu_rst=0, pc=0, prog_len=0, write pointer=0, busy=0, done=0.
- Program memory contents are not reset.
- States: IDLE, LOAD, CLEAR, RUN, PAUSE, DONE.
- ld_ready is a combinational decode: 1 in IDLE, LOAD and DONE; 0 otherwise. A beat is accepted when ld_valid and ld_ready are both high.
- Accepted beat in IDLE or DONE: starts a new load. Write mem[0], write pointer=1, prog_len=0, done=0, next state LOAD. If ld_last is also set, go straight to the end-of-load rule below.
- Accepted beat in LOAD: write mem[write pointer], increment the pointer.
- End of load: on an accepted beat with ld_last=1, or on the beat that fills address DEPTH-1 (forced end, ld_last ignored):
  - prog_len = number of beats accepted in this load
  - write pointer = 0
  - next state IDLE
- start while in LOAD is ignored.
- Simultaneous accepted beat and start in IDLE or DONE: the load wins and start is ignored.
- start in IDLE or DONE with prog_len != 0: next state CLEAR. start with prog_len == 0 is ignored.
- CLEAR lasts exactly one cycle: cpu_rst<=1, cpu_instr<=NOP, pc<=0, next state RUN. cpu_rst is 0 in every other cycle.
- RUN, per cycle:
  - If halt_req=1: cpu_instr<=NOP, no issue, next state PAUSE.
  - Otherwise issue: cpu_instr<=mem[pc], pc<=pc+1. If pc==prog_len-1, pc<=0 and next state DONE.
- Issue timing: cpu_instr is registered, so an instruction issued in cycle N is presented during cycle N+1 and sampled by the CPU at the end of N+1.
- Exactly prog_len instructions are issued per run, in address order, with no gaps unless halted.
- PAUSE: cpu_instr<=NOP each cycle, pc holds.
  - start resumes to RUN; issue continues on the following cycle.
  - step (with start=0) issues one instruction using the RUN issue rule, then stays in PAUSE, or goes to DONE if it was the last instruction.
  - If start and step arrive together, start wins.
  - halt_req is ignored in PAUSE.
- DONE: cpu_instr<=NOP, done=1. Stays until start (rerun, via CLEAR) or a load beat.
- pc wraps only via the DONE rule; it never exceeds prog_len-1.
- step in states other than PAUSE, and halt_req in states other than RUN, have no effect.
- Reset mid-run or mid-load returns to the reset values immediately. The partial load is discarded (prog_len=0) and cpu_rst is not pulsed.

Test Plan:
- Load and run: load 8'h05, 8'h13, 8'h22 (ld_last on the 3rd beat), then start.
  - prog_len=3.
  - cpu_rst high for exactly one cycle.
  - cpu_instr shows 05, 13, 22 on consecutive cycles, then F0.
  - done=1. CPU output_data ends at 8'h06.
- Halt and step: load 4 instructions, start, assert halt_req during the cycle after the 2nd issue.
  - cpu_instr goes to F0, pc=2, busy=1.
  - Two step pulses issue instructions 3 and 4, then done=1.
  - start in DONE reruns all 4 after a new cpu_rst pulse.
- Load overflow: stream 17 beats with ld_valid held high and no ld_last.
  - 16 beats accepted, prog_len=16.
  - State returns to IDLE with ld_ready=1; the 17th beat starts a new load with prog_len=0.
  - Verify the memory contents of the first load before the 17th beat.
- Ignored controls:
  - start with prog_len=0 leaves state IDLE and cpu_rst=0.
  - start asserted together with an accepted load beat in IDLE: no run starts.
  - halt_req and step in IDLE change nothing.
- Reset mid-run: assert rst while in RUN at pc=1.
  - Next cycle: cpu_instr=F0, pc=0, prog_len=0, busy=0, done=0, cpu_rst=0.
  - start is then ignored until a new program is loaded.

Source files
------------

// File: rtl/cpu_program_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_program_sequencer_if
// Brief    : Host-to-sequencer program load stream (valid/ready with last).
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_program_sequencer_if;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_data;
    logic       ld_last;

    modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
    modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface
`default_nettype wire

// File: rtl/cpu_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_program_sequencer
// Brief    : Loads a small program from a host and feeds it, one instruction
//            per cycle, to the accumulator CPU with clear/halt/step/resume.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_program_sequencer #(
    parameter int         AW  = 4,
    parameter logic [7:0] NOP = 8'hF0
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    cpu_program_sequencer_if.slave    ld,
    input  wire logic                 start,
    input  wire logic                 halt_req,
    input  wire logic                 step,
    output logic [7:0]                cpu_instr,
    output logic                      cpu_rst,
    output logic [AW-1:0]             pc,
    output logic [AW:0]               prog_len,
    output logic                      busy,
    output logic                      done
);
    localparam int c_DEPTH = 2 ** AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      instr_q, instr_d;
    logic            crst_q, crst_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW:0]     len_q, len_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [7:0]      mem [c_DEPTH];

    logic            w_accept;
    logic            w_start_load;
    logic            w_end_load;
    logic            w_last_instr;
    logic            w_issue;
    logic [AW-1:0]   w_mem_waddr;

    assign ld.ld_ready   = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DONE);
    assign w_accept      = ld.ld_valid && ld.ld_ready;
    // A beat outside LOAD always restarts the program at address 0.
    assign w_start_load  = w_accept && (state_q != S_LOAD);
    assign w_mem_waddr   = w_start_load ? '0 : wptr_q;
    assign w_end_load    = w_accept && (ld.ld_last || (&w_mem_waddr));
    assign w_last_instr  = ({1'b0, pc_q} == (len_q - 1'b1));

    always_comb begin
        state_d = state_q;
        instr_d = NOP;
        crst_d  = 1'b0;
        pc_d    = pc_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        w_issue = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    wptr_d  = {{(AW-1){1'b0}}, 1'b1};
                    len_d   = '0;
                    state_d = S_LOAD;
                end else if (start && (len_q != '0)) begin
                    state_d = S_CLEAR;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    wptr_d = wptr_q + 1'b1;
                end
            end
            S_CLEAR: begin
                crst_d  = 1'b1;
                pc_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_PAUSE;
                end else begin
                    w_issue = 1'b1;
                end
            end
            S_PAUSE: begin
                if (start) begin
                    state_d = S_RUN;
                end else if (step) begin
                    w_issue = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_end_load) begin
            len_d   = {1'b0, w_mem_waddr} + 1'b1;
            wptr_d  = '0;
            state_d = S_IDLE;
        end

        // Shared by RUN and single-step; a step on the last word finishes the run.
        if (w_issue) begin
            instr_d = mem[pc_q];
            if (w_last_instr) begin
                pc_d    = '0;
                state_d = S_DONE;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end

        busy_d = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= NOP;
            crst_q  <= 1'b0;
            pc_q    <= '0;
            wptr_q  <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            crst_q  <= crst_d;
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            mem[w_mem_waddr] <= ld.ld_data;
        end
    end

    assign cpu_instr = instr_q;
    assign cpu_rst   = crst_q;
    assign pc        = pc_q;
    assign prog_len  = len_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_program_sequencer
// Brief    : Directed and randomized bench for cpu_program_sequencer with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_program_sequencer;
    localparam int         AW  = 4;
    localparam logic [7:0] NOP = 8'hF0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, halt_req = 1'b0, step = 1'b0;
    logic [7:0]    cpu_instr;
    logic          cpu_rst;
    logic [AW-1:0] pc;
    logic [AW:0]   prog_len;
    logic          busy, done;

    cpu_program_sequencer_if ldif ();

    cpu_program_sequencer #(.AW(AW), .NOP(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ldif.slave),
        .start     (start),
        .halt_req  (halt_req),
        .step      (step),
        .cpu_instr (cpu_instr),
        .cpu_rst   (cpu_rst),
        .pc        (pc),
        .prog_len  (prog_len),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the program is an array, a run is "issue index e_pc of e_len".
    bit         mdl_on = 1'b0;
    logic [7:0] m_mem [16];
    int         m_loaded;
    bit         m_loading, m_clearing, m_running, m_paused, m_finished;
    logic [7:0] e_instr = NOP;
    bit         e_rst;
    int         e_pc, e_len;

    task automatic issue_one();
        e_instr = m_mem[e_pc];
        if (e_pc == e_len - 1) begin
            e_pc       = 0;
            m_running  = 1'b0;
            m_paused   = 1'b0;
            m_finished = 1'b1;
        end else begin
            e_pc++;
        end
    endtask

    always @(posedge clk) begin : model
        bit acc;
        acc     = ldif.ld_valid && !(m_clearing || m_running || m_paused);
        e_instr = NOP;
        e_rst   = 1'b0;
        if (rst) begin
            m_loading = 0; m_clearing = 0; m_running = 0; m_paused = 0; m_finished = 0;
            m_loaded = 0; e_pc = 0; e_len = 0;
        end else if (acc) begin
            if (!m_loading) begin
                m_loading  = 1'b1;
                m_loaded   = 0;
                m_finished = 1'b0;
                e_len      = 0;
            end
            m_mem[m_loaded] = ldif.ld_data;
            m_loaded++;
            if (ldif.ld_last || m_loaded == 16) begin
                e_len     = m_loaded;
                m_loading = 1'b0;
            end
        end else if (m_clearing) begin
            m_clearing = 1'b0;
            m_running  = 1'b1;
            e_rst      = 1'b1;
            e_pc       = 0;
        end else if (m_running) begin
            if (halt_req) begin
                m_running = 1'b0;
                m_paused  = 1'b1;
            end else begin
                issue_one();
            end
        end else if (m_paused) begin
            if (start) begin
                m_paused  = 1'b0;
                m_running = 1'b1;
            end else if (step) begin
                issue_one();
            end
        end else if (!m_loading && start && e_len != 0) begin
            m_clearing = 1'b1;
            m_finished = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            cmp("cpu_instr", 32'(cpu_instr), 32'(e_instr));
            cmp("cpu_rst",   32'(cpu_rst),   32'(e_rst));
            cmp("pc",        32'(pc),        32'(e_pc));
            cmp("prog_len",  32'(prog_len),  32'(e_len));
            cmp("busy",      32'(busy),      32'(m_clearing || m_running || m_paused));
            cmp("done",      32'(done),      32'(m_finished));
            cmp("ld_ready",  32'(ldif.ld_ready), 32'(!(m_clearing || m_running || m_paused)));
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit l,
                       input bit s, input bit h, input bit st, input bit r);
        ldif.ld_valid = v;
        ldif.ld_data  = d;
        ldif.ld_last  = l;
        start         = s;
        halt_req      = h;
        step          = st;
        rst           = r;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
    endtask

    logic [7:0] seen_instr [5];
    logic       seen_rst [5];
    int         n_rst, n_issue;

    initial begin
        ldif.ld_valid = 1'b0;
        ldif.ld_data  = 8'h00;
        ldif.ld_last  = 1'b0;

        cyc(0, 8'h00, 0, 0, 0, 0, 1);
        mdl_on = 1'b1;
        cyc(0, 8'h00, 0, 0, 0, 0, 1);
        cmp("reset cpu_instr", 32'(cpu_instr), 32'hF0);
        cmp("reset busy", 32'(busy), 32'd0);

        // Load and run 05,13,22
        cyc(1, 8'h05, 0, 0, 0, 0, 0);
        cyc(1, 8'h13, 0, 0, 0, 0, 0);
        cyc(1, 8'h22, 1, 0, 0, 0, 0);
        cmp("t1 prog_len", 32'(prog_len), 32'd3);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            idle();
            seen_instr[k] = cpu_instr;
            seen_rst[k]   = cpu_rst;
        end
        cmp("t1 instr0", 32'(seen_instr[0]), 32'hF0);
        cmp("t1 instr1", 32'(seen_instr[1]), 32'h05);
        cmp("t1 instr2", 32'(seen_instr[2]), 32'h13);
        cmp("t1 instr3", 32'(seen_instr[3]), 32'h22);
        cmp("t1 instr4", 32'(seen_instr[4]), 32'hF0);
        cmp("t1 rst pulse", 32'({seen_rst[0], seen_rst[1], seen_rst[2], seen_rst[3], seen_rst[4]}), 32'b10000);
        cmp("t1 done", 32'(done), 32'd1);

        // Halt and step
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h11 * (i + 1)), (i == 3), 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        idle(); idle(); idle();
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        cmp("t2 halt instr", 32'(cpu_instr), 32'hF0);
        cmp("t2 halt pc", 32'(pc), 32'd2);
        cmp("t2 halt busy", 32'(busy), 32'd1);
        idle();
        cyc(0, 8'h00, 0, 0, 0, 1, 0);
        cmp("t2 step1 instr", 32'(cpu_instr), 32'h33);
        cmp("t2 step1 done", 32'(done), 32'd0);
        idle();
        cyc(0, 8'h00, 0, 0, 0, 1, 0);
        cmp("t2 step2 instr", 32'(cpu_instr), 32'h44);
        cmp("t2 step2 done", 32'(done), 32'd1);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        n_rst = 0; n_issue = 0;
        for (int k = 0; k < 7; k++) begin
            idle();
            if (cpu_rst) n_rst++;
            if (cpu_instr != NOP) n_issue++;
        end
        cmp("t2 rerun rst count", 32'(n_rst), 32'd1);
        cmp("t2 rerun issues", 32'(n_issue), 32'd4);
        cmp("t2 rerun done", 32'(done), 32'd1);

        // Overflow: 16 beats fill memory, then run to verify contents
        for (int i = 0; i < 16; i++) cyc(1, 8'($urandom), 0, 0, 0, 0, 0);
        cmp("t3 prog_len", 32'(prog_len), 32'd16);
        cmp("t3 ld_ready", 32'(ldif.ld_ready), 32'd1);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        for (int k = 0; k < 20; k++) idle();
        cmp("t3 run done", 32'(done), 32'd1);
        // Continuous 17-beat stream
        for (int i = 0; i < 17; i++) begin
            cyc(1, 8'($urandom), 0, 0, 0, 0, 0);
            if (i == 15) cmp("t3b prog_len16", 32'(prog_len), 32'd16);
        end
        cmp("t3b prog_len after 17", 32'(prog_len), 32'd0);
        cmp("t3b ld_ready", 32'(ldif.ld_ready), 32'd1);
        cyc(1, 8'h42, 1, 0, 0, 0, 0);

        // Ignored controls
        cyc(0, 8'h00, 0, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        idle();
        cmp("t4 start len0 busy", 32'(busy), 32'd0);
        cmp("t4 start len0 rst", 32'(cpu_rst), 32'd0);
        cyc(1, 8'h07, 1, 1, 0, 0, 0);
        idle();
        cmp("t4 load+start busy", 32'(busy), 32'd0);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 1, 0);
        cmp("t4 halt/step pc", 32'(pc), 32'd0);
        cmp("t4 halt/step instr", 32'(cpu_instr), 32'hF0);

        // Reset mid-run
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h21 + i), (i == 3), 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        idle(); idle();
        cmp("t5 pc before rst", 32'(pc), 32'd1);
        cyc(0, 8'h00, 0, 0, 0, 0, 1);
        cmp("t5 instr", 32'(cpu_instr), 32'hF0);
        cmp("t5 pc", 32'(pc), 32'd0);
        cmp("t5 prog_len", 32'(prog_len), 32'd0);
        cmp("t5 busy", 32'(busy), 32'd0);
        cmp("t5 done", 32'(done), 32'd0);
        cmp("t5 cpu_rst", 32'(cpu_rst), 32'd0);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        idle();
        cmp("t5 start ignored", 32'(busy), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 9) < 4), 8'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 6) == 0), ($urandom_range(0, 249) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
